// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for the shared single-port instruction/data memory.
// One access per IDLE -> ACCESS -> DONE sequence; all outputs registered.
module mem_port_arbiter #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic          WE0,
  input  logic [AW-1:0] ADDR0,
  input  logic [DW-1:0] WDATA0,
  input  logic          REQ1,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA1,
  output logic          GNT0,
  output logic          GNT1,
  output logic          ACK0,
  output logic          ACK1,
  output logic [DW-1:0] RDATA,
  output logic          M_CS,
  output logic          M_WE,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic [DW-1:0] M_RDATA,
  output logic          OWNER
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state, state_nxt;

  logic          want, pick;
  logic          gnt0_n, gnt1_n, ack0_n, ack1_n, cs_n, we_n, owner_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n, rdata_n;

  // On a tie the master that did not own the memory last time wins.
  always_comb begin
    want = REQ0 | REQ1;
    pick = (REQ0 && REQ1) ? ~OWNER : REQ1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (want) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; anything not touched holds.
  always_comb begin
    gnt0_n  = GNT0;
    gnt1_n  = GNT1;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    cs_n    = M_CS;
    we_n    = M_WE;
    addr_n  = M_ADDR;
    wdata_n = M_WDATA;
    rdata_n = RDATA;
    owner_n = OWNER;
    case (state)
      IDLE: begin
        if (want) begin
          owner_n = pick;
          cs_n    = 1'b1;
          gnt0_n  = ~pick;
          gnt1_n  = pick;
          we_n    = pick ? WE1    : WE0;
          addr_n  = pick ? ADDR1  : ADDR0;
          wdata_n = pick ? WDATA1 : WDATA0;
        end
      end
      ACCESS: begin
        if (!M_WE) rdata_n = M_RDATA;
        cs_n   = 1'b0;
        we_n   = 1'b0;
        ack0_n = GNT0;
        ack1_n = GNT1;
      end
      DONE: begin
        gnt0_n = 1'b0;
        gnt1_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      ACK0    <= 1'b0;
      ACK1    <= 1'b0;
      M_CS    <= 1'b0;
      M_WE    <= 1'b0;
      M_ADDR  <= '0;
      M_WDATA <= '0;
      RDATA   <= '0;
      OWNER   <= 1'b1;
    end else begin
      GNT0    <= gnt0_n;
      GNT1    <= gnt1_n;
      ACK0    <= ack0_n;
      ACK1    <= ack1_n;
      M_CS    <= cs_n;
      M_WE    <= we_n;
      M_ADDR  <= addr_n;
      M_WDATA <= wdata_n;
      RDATA   <= rdata_n;
      OWNER   <= owner_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps then random two-master traffic,
// checked each cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0, WE0, REQ1, WE1;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [DW-1:0] WDATA0, WDATA1;
  logic          GNT0, GNT1, ACK0, ACK1, M_CS, M_WE, OWNER;
  logic [DW-1:0] RDATA, M_WDATA, M_RDATA;
  logic [AW-1:0] M_ADDR;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0),
    .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1),
    .RDATA(RDATA), .M_CS(M_CS), .M_WE(M_WE), .M_ADDR(M_ADDR),
    .M_WDATA(M_WDATA), .M_RDATA(M_RDATA), .OWNER(OWNER)
  );

  // Environment memory: the 128x32 array the arbiter drives.
  logic [DW-1:0] mem [0:127];
  logic          init_phase;

  function automatic logic [DW-1:0] init_val(input int unsigned i);
    if (i == 0) return 32'h2001_0006;
    return 32'h1000_0000 ^ (i * 32'h9E37_79B1);
  endfunction

  assign M_RDATA = mem[M_ADDR];

  always @(posedge CLK) begin
    if (init_phase) begin
      for (int unsigned i = 0; i < 128; i++) mem[i] <= init_val(i);
    end else if (M_CS && M_WE) begin
      mem[M_ADDR] <= M_WDATA;
    end
  end

  // Reference model: a transaction is either absent (-1), in its memory cycle (0)
  // or in its completion cycle (1); a new one can start only when absent.
  logic [DW-1:0] ref_mem [0:127];
  int            since = -1;
  bit            mo = 1'b1;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (since == 0 && m_we) ref_mem[m_addr] = m_wdata;
    if (!RST) begin
      since = -1; mo = 1'b1; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (since == 0) begin
      if (!m_we) m_rdata = ref_mem[m_addr];
      since = 1;
    end else if (since == 1) begin
      since = -1;
    end else if (REQ0 || REQ1) begin
      mo      = (REQ0 && REQ1) ? !mo : REQ1;
      m_we    = mo ? WE1 : WE0;
      m_addr  = mo ? ADDR1 : ADDR0;
      m_wdata = mo ? WDATA1 : WDATA0;
      since   = 0;
    end
  endtask

  task automatic check_outputs();
    chk("GNT0",     32'(GNT0),    32'(since >= 0 && !mo));
    chk("GNT1",     32'(GNT1),    32'(since >= 0 && mo));
    chk("ACK0",     32'(ACK0),    32'(since == 1 && !mo));
    chk("ACK1",     32'(ACK1),    32'(since == 1 && mo));
    chk("M_CS",     32'(M_CS),    32'(since == 0));
    chk("M_WE",     32'(M_WE),    32'(since == 0 && m_we));
    chk("M_ADDR",   32'(M_ADDR),  32'(m_addr));
    chk("M_WDATA",  M_WDATA,      m_wdata);
    chk("RDATA",    RDATA,        m_rdata);
    chk("OWNER",    32'(OWNER),   32'(mo));
    chk("gnt_excl", 32'(GNT0 & GNT1), 32'd0);
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic do_txn(input bit m, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 1'b0;
    if (!m) begin REQ0 = 1'b1; WE0 = we; ADDR0 = a; WDATA0 = d; end
    else    begin REQ1 = 1'b1; WE1 = we; ADDR1 = a; WDATA1 = d; end
    for (int i = 0; i < 12 && !got; i++) begin
      cycle();
      got = m ? ACK1 : ACK0;
    end
    chk(m ? "ack1_seen" : "ack0_seen", 32'(got), 32'd1);
    if (!m) REQ0 = 1'b0; else REQ1 = 1'b0;
  endtask

  task automatic new_req(input bit m);
    if (!m) begin
      REQ0 = 1'b1; WE0 = 1'($urandom_range(1)); ADDR0 = AW'($urandom); WDATA0 = $urandom;
    end else begin
      REQ1 = 1'b1; WE1 = 1'($urandom_range(1)); ADDR1 = AW'($urandom); WDATA1 = $urandom;
    end
  endtask

  initial begin
    int a0, a1, first, w0, w1;
    bit got;
    for (int unsigned i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    RST = 1'b0; init_phase = 1'b1;
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = '0; WDATA0 = '0;
    REQ1 = 1'b0; WE1 = 1'b0; ADDR1 = '0; WDATA1 = '0;

    // Reset held three cycles with a pending request.
    cycle();
    init_phase = 1'b0;
    cycle();
    cycle();
    chk("rst_owner", 32'(OWNER), 32'd1);
    chk("rst_cs",    32'(M_CS),  32'd0);
    RST = 1'b1;
    cycle();
    chk("rel_gnt0", 32'(GNT0), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin cycle(); got = ACK0; end
    chk("rel_ack0", 32'(got), 32'd1);
    REQ0 = 1'b0;
    cycle();

    // Master 1 write then read back.
    do_txn(1'b1, 1'b1, 7'd5, 32'hDEAD_BEEF);
    do_txn(1'b1, 1'b0, 7'd5, 32'h0);
    chk("m1_rdback", RDATA, 32'hDEAD_BEEF);
    cycle();

    // Both requesting continuously: 4 accesses in 12 cycles, alternating.
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 7'd1;
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 7'd2;
    a0 = 0; a1 = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (ACK0) a0++;
      if (ACK1) a1++;
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    chk("rr_ack0_cnt", 32'(a0), 32'd2);
    chk("rr_ack1_cnt", 32'(a1), 32'd2);
    chk("rr_last_owner", 32'(OWNER), 32'd1);

    // Master 0 read of preloaded word races a master 1 write.
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 7'd0;
    REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 7'd10; WDATA1 = 32'hCAFE_F00D;
    first = -1;
    for (int i = 0; i < 16 && (REQ0 || REQ1); i++) begin
      cycle();
      if (ACK0) begin REQ0 = 1'b0; if (first < 0) first = 0; end
      if (ACK1) begin REQ1 = 1'b0; if (first < 0) first = 1; end
    end
    chk("race_first", 32'(first), 32'd0);
    chk("race_rdata", RDATA, 32'h2001_0006);
    chk("race_done",  32'(REQ0 | REQ1), 32'd0);
    cycle();

    // Address change and request drop after grant.
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 7'd3;
    cycle();
    chk("lat_addr", 32'(M_ADDR), 32'd3);
    ADDR0 = 7'd9; REQ0 = 1'b0;
    cycle();
    chk("drop_ack0", 32'(ACK0), 32'd1);
    cycle();
    cycle();

    // Reset during ACCESS abandons the transaction.
    REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 7'd20; WDATA1 = 32'h1234_5678;
    cycle();
    chk("mid_cs", 32'(M_CS), 32'd1);
    RST = 1'b0; REQ1 = 1'b0;
    cycle();
    chk("mid_rst_cs",   32'(M_CS), 32'd0);
    chk("mid_rst_gnt1", 32'(GNT1), 32'd0);
    RST = 1'b1;
    cycle();
    chk("mid_rst_ack1", 32'(ACK1), 32'd0);
    do_txn(1'b0, 1'b0, 7'd20, 32'h0);
    cycle();

    // Random two-master traffic.
    w0 = 0; w1 = 0;
    for (int c = 0; c < 400; c++) begin
      cycle();
      if (REQ0) w0++;
      if (REQ1) w1++;
      if (REQ0 && ACK0) begin
        chk("starve0", 32'(w0 <= 8), 32'd1);
        w0 = 0;
        if ($urandom_range(3) == 0) new_req(1'b0); else REQ0 = 1'b0;
      end else if (!REQ0 && $urandom_range(1) == 1) new_req(1'b0);
      if (REQ1 && ACK1) begin
        chk("starve1", 32'(w1 <= 8), 32'd1);
        w1 = 0;
        if ($urandom_range(3) == 0) new_req(1'b1); else REQ1 = 1'b0;
      end else if (!REQ1 && $urandom_range(1) == 1) new_req(1'b1);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
